// File: rtl/fetch_ctrl.sv
`timescale 1ns/1ps
// fetch_ctrl
//
// Owns the architectural PC and sequences instruction fetch for the
// single-issue front end. At most one instruction-memory request is
// outstanding. A fetched word is held in a one-entry output buffer until
// downstream takes it. Redirects (branch/jump targets) are applied here.
// Fetch stops permanently on an accepted HALT until rst.
//
// Optional feature macro: FETCH_EXC_EN
//   When defined, this adds the exc_req/rti inputs, the epc output and the
//   epc register. exc_req redirects to EXC_VECTOR and saves the PC of the
//   oldest unaccepted instruction. rti redirects to epc.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   imem_req/addr      fetch request and its address (addr = pc)
//   imem_done/data     memory completion and the returned instruction word
//   if_valid/instr     buffered instruction towards decode
//   if_pc/if_pc_plus2  address of the buffered instruction and that address + 2
//   if_ready           downstream accepts the buffered instruction
//   redirect/_pc       one-cycle redirect pulse and its target
//   halt               marks the instruction being accepted as HALT
//   halted             fetch has stopped
//   exc_req, rti, epc  exception entry/return (FETCH_EXC_EN only)
//
// Handshakes:
//   imem: imem_req is held high, with imem_addr constant, from the first
//     cycle of a request until the cycle in which imem_done is sampled high.
//     imem_done may already be high in that first cycle. Each done completes
//     exactly one request.
//   if:   a transfer happens on a rising edge where if_valid && if_ready.
//     While if_valid && !if_ready, the buffered instruction and its PC hold
//     steady. if_valid never depends combinationally on if_ready.
//
// Every output comes from a flop or from a decode of state_q. There is no
// combinational path from any input to any output.

module fetch_ctrl #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] EXC_VECTOR = 16'h0002
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_done,
  input  logic [15:0] imem_data,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_plus2,
  input  logic        if_ready,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        halted
`ifdef FETCH_EXC_EN
  ,
  input  logic        exc_req,
  input  logic        rti,
  output logic [15:0] epc
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_VALID  = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] if_instr_q, if_instr_d;
  logic [15:0] if_pc_q, if_pc_d;
  logic [15:0] if_pc_plus2_q, if_pc_plus2_d;
  logic        halted_q, halted_d;
  // squash_q: the in-flight request has been overtaken by a redirect.
  // Its data must be dropped, and target_q is then loaded into pc.
  logic        squash_q, squash_d;
  logic [15:0] target_q, target_d;

  // Exception controls. In the default build these collapse to constants,
  // so the redirect mux below has the same form in both builds.
  logic        exc_take;
  logic        rti_take;
  logic [15:0] epc_val;

`ifdef FETCH_EXC_EN
  logic [15:0] epc_q, epc_d;
  assign exc_take = exc_req;
  assign rti_take = rti & ~exc_req;
  assign epc_val  = epc_q;
  assign epc      = epc_q;
`else
  assign exc_take = 1'b0;
  assign rti_take = 1'b0;
  assign epc_val  = 16'h0000;
`endif

  // The redirect source is chosen by priority: exc_req, then rti, then
  // redirect. Instructions are halfword aligned, so bit 0 of every target
  // is cleared.
  logic        redir_take;
  logic [15:0] redir_raw;
  logic [15:0] redir_tgt;

  assign redir_take = exc_take | rti_take | redirect;
  assign redir_raw  = exc_take ? EXC_VECTOR :
                      rti_take ? epc_val    : redirect_pc;
  assign redir_tgt  = redir_raw & 16'hFFFE;

  // Outputs: decoded from state only, or taken straight from flops.
  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign if_valid    = (state_q == S_VALID);
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_pc_plus2 = if_pc_plus2_q;
  assign halted      = halted_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_pc_plus2_d = if_pc_plus2_q;
    halted_d      = halted_q;
    squash_d      = squash_q;
    target_d      = target_q;
`ifdef FETCH_EXC_EN
    epc_d         = epc_q;
`endif

    case (state_q)
      // One dead cycle after reset, so that req never rises in the
      // reset-release cycle.
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
`ifdef FETCH_EXC_EN
        if (exc_take) epc_d = pc_q;
`endif
        if (imem_done) begin
          if (squash_q || redir_take) begin
            // Drop the returned word. A same-cycle redirect is newer than
            // any pending target, so it wins.
            pc_d     = redir_take ? redir_tgt : target_q;
            squash_d = 1'b0;
          end else begin
            if_instr_d    = imem_data;
            if_pc_d       = pc_q;
            if_pc_plus2_d = pc_q + 16'd2;
            state_d       = S_VALID;
          end
        end else if (redir_take) begin
          // imem_addr must not move mid-request. Remember the target and
          // wait for the outstanding completion. A later redirect
          // overwrites the stored target.
          target_d = redir_tgt;
          squash_d = 1'b1;
        end
      end

      S_VALID: begin
        if (exc_take || rti_take) begin
          // The exception or return replaces the buffered instruction,
          // even if downstream is ready to take it this cycle.
`ifdef FETCH_EXC_EN
          if (exc_take) epc_d = if_pc_q;
`endif
          pc_d    = redir_tgt;
          state_d = S_FETCH;
        end else if (if_ready && halt) begin
          halted_d = 1'b1;
          state_d  = S_HALTED;
        end else if (if_ready) begin
          pc_d    = redirect ? redir_tgt : if_pc_plus2_q;
          state_d = S_FETCH;
        end else if (redirect) begin
          pc_d    = redir_tgt;
          state_d = S_FETCH;
        end
      end

      S_HALTED: begin
        // Terminal until reset. All inputs are ignored.
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      if_instr_q    <= 16'h0000;
      if_pc_q       <= 16'h0000;
      if_pc_plus2_q <= 16'h0000;
      halted_q      <= 1'b0;
      squash_q      <= 1'b0;
      target_q      <= 16'h0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus2_q <= if_pc_plus2_d;
      halted_q      <= halted_d;
      squash_q      <= squash_d;
      target_q      <= target_d;
    end
  end

`ifdef FETCH_EXC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc_q <= 16'h0000;
    end else begin
      epc_q <= epc_d;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
`timescale 1ns/1ps
// Testbench for fetch_ctrl.
//
// The instruction memory is a bench-side responder with a configurable or
// random latency. The word it returns for address a is a ^ 16'hC3A5.
//
// The reference model works at the level of the architectural instruction
// stream. After an accepted instruction at p, the next accepted instruction
// must be at p+2, unless a redirect was seen since then (or in the same
// cycle); in that case it must be at the last redirect target with bit 0
// cleared. An accepted HALT ends the stream.

module tb_fetch_ctrl;
  localparam logic [15:0] RESET_PC   = 16'h0000;
  localparam logic [15:0] EXC_VECTOR = 16'h0002;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_done;
  logic [15:0] imem_data;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_plus2;
  logic        if_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        halted;
`ifdef FETCH_EXC_EN
  logic        exc_req;
  logic        rti;
  logic [15:0] epc;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Memory responder state
  int          mem_lat;     // extra wait cycles; -1 picks a random 0..3
  int          wait_left;
  bit          in_req;
  logic [15:0] req_addr;

  // Reference model state
  logic [15:0] exp_pc;
  bit          exp_halted;
  int          acc_cnt;
`ifdef FETCH_EXC_EN
  logic [15:0] model_epc;
`endif

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  fetch_ctrl #(
    .RESET_PC   (RESET_PC),
    .EXC_VECTOR (EXC_VECTOR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_done   (imem_done),
    .imem_data   (imem_data),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus2 (if_pc_plus2),
    .if_ready    (if_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .halted      (halted)
`ifdef FETCH_EXC_EN
    ,
    .exc_req     (exc_req),
    .rti         (rti),
    .epc         (epc)
`endif
  );

  function automatic logic [15:0] instr_of(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc     = RESET_PC;
    exp_halted = 1'b0;
    in_req     = 1'b0;
`ifdef FETCH_EXC_EN
    model_epc  = 16'h0000;
`endif
  endtask

  // Called once per cycle, between edges. Inputs for the coming edge are
  // already driven.
  task automatic model_update();
    logic [15:0] tgt;
    bit          redir;
    bit          exc_rti;
    tgt     = redirect_pc & 16'hFFFE;
    redir   = redirect;
    exc_rti = 1'b0;
`ifdef FETCH_EXC_EN
    if (exc_req) begin
      redir = 1'b1; exc_rti = 1'b1; tgt = EXC_VECTOR & 16'hFFFE; model_epc = exp_pc;
    end else if (rti) begin
      redir = 1'b1; exc_rti = 1'b1; tgt = model_epc;
    end
`endif
    if (exp_halted) begin
      check("halted_hold", halted, 1'b1);
      check("halted_no_req", imem_req, 1'b0);
      check("halted_no_valid", if_valid, 1'b0);
    end else if (if_valid && if_ready && !exc_rti) begin
      acc_cnt++;
      check("acc_pc", if_pc, exp_pc);
      check("acc_instr", if_instr, instr_of(exp_pc));
      check("acc_pc_plus2", if_pc_plus2, exp_pc + 16'd2);
      if (halt) exp_halted = 1'b1;
      else      exp_pc = redir ? tgt : exp_pc + 16'd2;
    end else if (redir && (imem_req || if_valid)) begin
      exp_pc = tgt;
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle. The task starts 1 ns after a rising edge and returns
  // 1 ns after the next one.
  task automatic step();
    if (imem_req) begin
      if (!in_req) begin
        in_req    = 1'b1;
        req_addr  = imem_addr;
        wait_left = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
      end else begin
        check("imem_addr_stable", imem_addr, req_addr);
      end
      if (wait_left == 0) begin
        imem_done = 1'b1;
        imem_data = instr_of(imem_addr);
        in_req    = 1'b0;
      end else begin
        imem_done = 1'b0;
        imem_data = 16'($urandom);
        wait_left--;
      end
    end else begin
      imem_done = 1'b0;
      in_req    = 1'b0;
    end
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    redirect  = 1'b0;
    halt      = 1'b0;
    if_ready  = 1'b0;
    imem_done = 1'b0;
`ifdef FETCH_EXC_EN
    exc_req   = 1'b0;
    rti       = 1'b0;
`endif
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [15:0] saved_pc;
    logic [15:0] saved_instr;
    int          acc0;

    rst = 1'b1; imem_done = 1'b0; imem_data = 16'h0000; if_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 16'h0000; halt = 1'b0;
`ifdef FETCH_EXC_EN
    exc_req = 1'b0; rti = 1'b0;
`endif
    mem_lat = 0; acc_cnt = 0; wait_left = 0; req_addr = 16'h0000;
    model_reset();

    // Reset values
    #12;
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", if_valid, 1'b0);
    check("rst_instr", if_instr, 16'h0000);
    check("rst_halted", halted, 1'b0);
    check("rst_addr", imem_addr, RESET_PC);
`ifdef FETCH_EXC_EN
    check("rst_epc", epc, 16'h0000);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    check("release_no_req", imem_req, 1'b0);

    // Zero-latency memory, always ready: one instruction every 2 cycles
    mem_lat = 0; if_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check("b_req", imem_req, (k % 2 == 1) ? 1'b1 : 1'b0);
      if (k % 2 == 1) begin
        check("b_addr", imem_addr, 16'(k - 1));
      end else begin
        check("b_valid", if_valid, 1'b1);
        check("b_if_pc", if_pc, 16'(k - 2));
        check("b_if_pc_plus2", if_pc_plus2, 16'(k));
      end
    end

    // 3-cycle memory, downstream stalls for 4 cycles in VALID
    apply_reset();
    mem_lat = 2; if_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (if_valid) break;
      step();
    end
    check("c_valid", if_valid, 1'b1);
    check("c_first_pc", if_pc, RESET_PC);
    saved_pc = if_pc; saved_instr = if_instr;
    repeat (4) begin
      step();
      check("c_stall_valid", if_valid, 1'b1);
      check("c_stall_pc", if_pc, saved_pc);
      check("c_stall_instr", if_instr, saved_instr);
      check("c_stall_no_req", imem_req, 1'b0);
    end
    if_ready = 1'b1;
    step();
    check("c_release_req", imem_req, 1'b1);
    check("c_release_addr", imem_addr, saved_pc + 16'd2);

    // Redirect in the first cycle of a 3-cycle fetch of 0004
    apply_reset();
    mem_lat = 2; if_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (imem_req && imem_addr == 16'h0004) break;
      step();
    end
    check("d_reach_req", imem_req, 1'b1);
    check("d_reach_addr", imem_addr, 16'h0004);
    redirect = 1'b1; redirect_pc = 16'h0100;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req && imem_addr == 16'h0100) break;
      step();
      check("d_no_valid", if_valid, 1'b0);
    end
    check("d_new_req", imem_req, 1'b1);
    check("d_new_addr", imem_addr, 16'h0100);
    for (int i = 0; i < 20; i++) begin
      if (if_valid) break;
      step();
    end
    check("d_valid", if_valid, 1'b1);
    check("d_first_pc", if_pc, 16'h0100);

    // PC wrap and odd target
    apply_reset();
    mem_lat = 0; if_ready = 1'b1;
    step();
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    step();
    redirect = 1'b0;
    check("e_req", imem_req, 1'b1);
    check("e_addr_fffe", imem_addr, 16'hFFFE);
    step();
    check("e_if_pc", if_pc, 16'hFFFE);
    check("e_plus2_wrap", if_pc_plus2, 16'h0000);
    step();
    check("e_wrap_req", imem_req, 1'b1);
    check("e_wrap_addr", imem_addr, 16'h0000);
    redirect = 1'b1; redirect_pc = 16'h0103;
    step();
    redirect = 1'b0;
    check("e_odd_req", imem_req, 1'b1);
    check("e_odd_addr", imem_addr, 16'h0102);

    // HALT accepted at 0x0010, then async reset mid-run
    redirect = 1'b1; redirect_pc = 16'h0010;
    step();
    redirect = 1'b0;
    check("f_addr", imem_addr, 16'h0010);
    step();
    check("f_if_pc", if_pc, 16'h0010);
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("f_halted", halted, 1'b1);
    check("f_no_req", imem_req, 1'b0);
    check("f_no_valid", if_valid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      redirect = (i == 2); redirect_pc = 16'h0200;
      step();
    end
    redirect = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("f_arst_req", imem_req, 1'b0);
    check("f_arst_valid", if_valid, 1'b0);
    check("f_arst_halted", halted, 1'b0);
    check("f_arst_instr", if_instr, 16'h0000);
    check("f_arst_addr", imem_addr, RESET_PC);
    model_reset();
    imem_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("f_release_no_req", imem_req, 1'b0);
    @(posedge clk); #1;
    check("f_first_req", imem_req, 1'b1);
    check("f_first_addr", imem_addr, RESET_PC);

`ifdef FETCH_EXC_EN
    // Exception entry and return
    apply_reset();
    mem_lat = 0; if_ready = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect = 1'b0;
    step();
    check("g_if_pc", if_pc, 16'h0040);
    exc_req = 1'b1;
    step();
    exc_req = 1'b0;
    check("g_epc", epc, 16'h0040);
    check("g_exc_req", imem_req, 1'b1);
    check("g_exc_addr", imem_addr, EXC_VECTOR);
    step();
    check("g_vec_pc", if_pc, EXC_VECTOR);
    rti = 1'b1;
    step();
    rti = 1'b0;
    check("g_rti_req", imem_req, 1'b1);
    check("g_rti_addr", imem_addr, 16'h0040);
`endif

    // Random latency, backpressure and redirects against the stream model
    apply_reset();
    mem_lat = -1;
    acc0 = acc_cnt;
    for (int i = 0; i < 3000; i++) begin
      if_ready    = ($urandom_range(0, 3) != 0);
      redirect    = (i > 0) && ($urandom_range(0, 19) == 0);
      redirect_pc = 16'($urandom);
      step();
    end
    redirect = 1'b0;
    check("h_progress", (acc_cnt - acc0 > 100) ? 16'd1 : 16'd0, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
